// File: rtl/ad7606_emu.sv
// AD7606 device-side responder: BUSY/FRSTDATA/DB emulation for loopback.
// Optional macro AD7606_EMU_EXT_DATA_EN: sample data comes from ext_data.
module ad7606_emu #(
    parameter int BASE_CONV_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         convst_a,
    input  logic         convst_b,
    input  logic         cs_n,
    input  logic         rd_n,
    input  logic         ad_reset,
    input  logic [2:0]   os,
    input  logic         stby_n,
`ifdef AD7606_EMU_EXT_DATA_EN
    input  logic [127:0] ext_data,
`endif
    output logic         busy,
    output logic         frstdata,
    output logic [15:0]  db,
    output logic         db_oe,
    output logic [12:0]  frame_cnt
);

    typedef enum logic [1:0] {
        S_PWRDN,
        S_IDLE,
        S_CONV,
        S_DRDY
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_conv_q;
    logic        r_rd_q;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  r_ptr;
    logic [2:0]  w_ptr_nxt;
    logic        r_dv;
    logic        w_dv_nxt;
    logic [12:0] r_fcnt;
    logic [12:0] w_fcnt_nxt;
    logic [15:0] r_smp [8];
    logic [15:0] w_smp_src [8];
    logic        w_smp_load;
    logic        w_smp_clr;

    logic        w_conv;
    logic        w_start;
    logic        w_rd_adv;
    logic [2:0]  w_os_eff;
    logic [15:0] w_len;

    assign w_conv   = convst_a & convst_b;
    assign w_start  = w_conv & ~r_conv_q;
    assign w_rd_adv = rd_n & ~r_rd_q & ~cs_n;
    assign w_os_eff = (os <= 3'd6) ? os : 3'd0;
    assign w_len    = 16'(BASE_CONV_CYCLES << w_os_eff);

    // Sample source captured on the last conversion cycle
    always_comb begin
        for (int k = 0; k < 8; k++) begin
`ifdef AD7606_EMU_EXT_DATA_EN
            w_smp_src[k] = ext_data[16*k +: 16];
`else
            w_smp_src[k] = {3'(k), r_fcnt};
`endif
        end
    end

    // Edge-detect history for convst and rd_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conv_q <= 1'b0;
            r_rd_q   <= 1'b1;
        end else begin
            r_conv_q <= w_conv;
            r_rd_q   <= rd_n;
        end
    end

    // Next-state and datapath control; ad_reset outranks standby
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_dv_nxt    = r_dv;
        w_fcnt_nxt  = r_fcnt;
        w_smp_load  = 1'b0;
        w_smp_clr   = 1'b0;
        if (ad_reset) begin
            w_state_nxt = stby_n ? S_IDLE : S_PWRDN;
            w_cnt_nxt   = '0;
            w_ptr_nxt   = '0;
            w_dv_nxt    = 1'b0;
            w_fcnt_nxt  = '0;
            w_smp_clr   = 1'b1;
        end else if (!stby_n) begin
            w_state_nxt = S_PWRDN;
            w_cnt_nxt   = '0;
            w_dv_nxt    = 1'b0;
        end else begin
            unique case (r_state)
                S_PWRDN: begin
                    w_state_nxt = S_IDLE;
                end
                S_IDLE: begin
                    if (w_start) begin
                        w_state_nxt = S_CONV;
                        w_cnt_nxt   = w_len - 16'd1;
                        w_ptr_nxt   = '0;
                        w_dv_nxt    = 1'b0;
                    end
                end
                S_CONV: begin
                    if (r_cnt == 16'd0) begin
                        w_state_nxt = S_DRDY;
                        w_smp_load  = 1'b1;
                        w_fcnt_nxt  = r_fcnt + 13'd1;
                        w_dv_nxt    = 1'b1;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                end
                S_DRDY: begin
                    if (w_start) begin
                        w_state_nxt = S_CONV;
                        w_cnt_nxt   = w_len - 16'd1;
                        w_ptr_nxt   = '0;
                        w_dv_nxt    = 1'b0;
                    end else if (w_rd_adv) begin
                        w_ptr_nxt = r_ptr + 3'd1;
                        if (r_ptr == 3'd7) begin
                            w_dv_nxt = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_dv    <= 1'b0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_dv    <= w_dv_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Channel sample registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                r_smp[k] <= '0;
            end
        end else if (w_smp_clr) begin
            for (int k = 0; k < 8; k++) begin
                r_smp[k] <= '0;
            end
        end else if (w_smp_load) begin
            for (int k = 0; k < 8; k++) begin
                r_smp[k] <= w_smp_src[k];
            end
        end
    end

    assign busy      = (r_state == S_CONV);
    assign db        = cs_n ? 16'h0000 : r_smp[r_ptr];
    assign db_oe     = ~cs_n;
    assign frstdata  = r_dv & ~cs_n & (r_ptr == 3'd0);
    assign frame_cnt = r_fcnt;

endmodule

// File: doc/ad7606_emu.md
Name: ad7606_emu

Overview:
Synthesizable AD7606 device-side responder for CPLD loopback and bring-up. It answers the ADC control pins (CONVST A/B, CS, RD, RESET, OS, STBY) with BUSY, FRSTDATA and 16-bit parallel data, so the ADC controller can be exercised without silicon. Sample data is a deterministic per-channel pattern. It sits on the board-side ADC pins, or is muxed in place of them in test builds.

Parameters:
BASE_CONV_CYCLES, 16, BUSY width in clk cycles at OS=0 (4 us at 4 MHz); BASE_CONV_CYCLES*64 must be less than 65536.

Ports:
clk  in  1  system clock, 4 MHz
rst_n  in  1  asynchronous active-low reset
convst_a  in  1  conversion start A; rising edge starts a conversion
convst_b  in  1  conversion start B; ANDed with convst_a
cs_n  in  1  chip select, active low
rd_n  in  1  read strobe, active low
ad_reset  in  1  device reset, active high, sampled on clk
os  in  3  oversampling ratio select
stby_n  in  1  0 = power-down
busy  out  1  conversion in progress
frstdata  out  1  first-channel indicator
db  out  16  parallel data
db_oe  out  1  1 when db is driven, equal to ~cs_n
frame_cnt  out  13  completed conversions since reset

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, ptr=0, data_valid=0, frame_cnt=0, sample regs=0, edge registers=1 for rd_n and 0 for conv. frstdata and db follow the rules below, so they are 0 after reset.
- Edge detection: conv = convst_a & convst_b, registered once as conv_q. A start is the cycle where conv=1 and conv_q=0. An rd rise is the cycle where rd_n=1 and rd_q=0.
- os_eff = os when os ≤ 6, otherwise 0. Conversion length N = BASE_CONV_CYCLES << os_eff, latched at start.
- States:
  - PWRDN: entered when stby_n=0. busy=0, starts ignored, data_valid=0. Goes to IDLE when stby_n=1.
  - IDLE: on a start, busy=1 at that same clk edge, counter loaded with N-1, ptr=0, data_valid=0, go to CONV.
  - CONV: busy stays high for exactly N cycles. Starts are ignored. rd rises do not move ptr. Last cycle (counter=0):
    - busy=0.
    - sample[k] = {k[2:0], frame_cnt} for k=0..7.
    - frame_cnt incremented, wrapping 8191→0.
    - data_valid=1, ptr=0, go to DRDY.
  - DRDY: each rd rise with cs_n=0 advances ptr by 1 on the next clk edge. After ptr=7 the 8th rise wraps ptr to 0 and clears data_valid. A start behaves as in IDLE and aborts the read.
- db = sample[ptr] when cs_n=0, else 16'h0000. db is combinational from registers and valid while rd_n is low.
- frstdata = data_valid & ~cs_n & (ptr==0).
- Reads with cs_n=1 are ignored.
- Reads after wrap (data_valid=0) return ch1..ch8 again with frstdata=0.
- ad_reset=1: synchronous equivalent of rst_n, except that stby_n still takes priority (PWRDN). It aborts a conversion in progress with busy=0 on the next edge.
- Priority: rst_n > ad_reset > stby_n=0 > start > rd rise.
- A start and an rd rise in the same cycle: the start wins and ptr goes to 0.

Optional Feature:
AD7606_EMU_EXT_DATA_EN:
- Defined: adds input ext_data[127:0], where channel k is bits [16k+15:16k]. On the last CONV cycle, sample[k] loads from ext_data instead of the pattern. frame_cnt still increments.
- Undefined: port absent; pattern data only.

Test Plan:
- Reset, stby_n=1, os=0. Pulse convst_a=convst_b low→high. Required: busy high for exactly 16 cycles starting at the edge that samples the rise; frame_cnt becomes 1.
- After the first conversion, 8 rd_n pulses with cs_n=0. Required: db = 16'h0000, 16'h2000, 16'h4000, … 16'hE000. frstdata=1 only during the first pulse. After the 8th pulse, a 9th read returns 16'h0000 with frstdata=0.
- os=3: busy width is 128 cycles. os=7: busy width is 16 cycles.
- A second start while busy, at cycle 5: ignored, busy still falls at cycle 16. A start after 3 reads: ptr goes to 0, busy high, and the next frame returns {3'd0,13'd1} first.
- ad_reset=1 at cycle 8 of CONV: busy=0 next cycle, frame_cnt=0, data_valid=0. stby_n=0 during a start: busy stays 0.
- With AD7606_EMU_EXT_DATA_EN, ext_data channel 5 = 16'hA5A5: the 6th read returns 16'hA5A5.
